// File: rtl/elevator_car_controller.sv
// Single elevator car sequencer: pending-stop vector, SCAN direction policy,
// floor-to-floor travel timer and door dwell timer.
module elevator_car_controller #(
  parameter int FLOOR_COUNT   = 7,
  parameter int FLOOR_BITS    = 3,
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   assign_valid,
  input  logic [FLOOR_BITS-1:0]  assign_floor,
  output logic                   assign_ready,
  input  logic [FLOOR_COUNT-1:0] car_button,
  input  logic                   door_obstruct,
  output logic [FLOOR_BITS-1:0]  current_floor,
  output logic [1:0]             direction,
  output logic                   motor_up,
  output logic                   motor_down,
  output logic                   door_open,
  output logic [FLOOR_COUNT-1:0] pending
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_MOVING = 2'd1;
  localparam logic [1:0] S_DOORS  = 2'd2;

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DN   = 2'b10;

  localparam int TC_W = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DC_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TC_W-1:0] TC_LAST = TC_W'(TRAVEL_CYCLES - 1);
  localparam logic [DC_W-1:0] DC_LAST = DC_W'(DOOR_CYCLES - 1);

  // Floor indices beyond FLOOR_COUNT-1 map to an all-zero vector, which drops them.
  function automatic logic [FLOOR_COUNT-1:0] onehot(input logic [FLOOR_BITS-1:0] f);
    onehot = '0;
    for (int i = 0; i < FLOOR_COUNT; i++)
      if (f == FLOOR_BITS'(i)) onehot[i] = 1'b1;
  endfunction

  function automatic logic above_of(input logic [FLOOR_COUNT-1:0] v,
                                    input logic [FLOOR_BITS-1:0]  f);
    above_of = 1'b0;
    for (int i = 0; i < FLOOR_COUNT; i++)
      if (FLOOR_BITS'(i) > f) above_of = above_of | v[i];
  endfunction

  function automatic logic below_of(input logic [FLOOR_COUNT-1:0] v,
                                    input logic [FLOOR_BITS-1:0]  f);
    below_of = 1'b0;
    for (int i = 0; i < FLOOR_COUNT; i++)
      if (FLOOR_BITS'(i) < f) below_of = below_of | v[i];
  endfunction

  logic [1:0]             state_q, state_d;
  logic [1:0]             dir_q, dir_d;
  logic [FLOOR_BITS-1:0]  floor_q, floor_d;
  logic [FLOOR_COUNT-1:0] pending_q, pending_d;
  logic [TC_W-1:0]        tc_q, tc_d;
  logic [DC_W-1:0]        dc_q, dc_d;
  logic                   ready_q;

  logic [FLOOR_COUNT-1:0] set_v;
  logic [FLOOR_COUNT-1:0] clr_v;
  logic                   here, above, below, restart;

  always_comb begin
    set_v   = car_button | ((assign_valid && ready_q) ? onehot(assign_floor) : '0);
    here    = |(pending_q & onehot(floor_q));
    above   = above_of(pending_q, floor_q);
    below   = below_of(pending_q, floor_q);
    restart = door_obstruct | (|(set_v & onehot(floor_q)));
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    floor_d = floor_q;
    tc_d    = tc_q;
    dc_d    = dc_q;
    case (state_q)
      S_IDLE: begin
        if (here) begin
          state_d = S_DOORS;
          dc_d    = '0;
        end else if (dir_q == DIR_DN && below) begin
          state_d = S_MOVING;
          dir_d   = DIR_DN;
          tc_d    = '0;
        end else if (above) begin
          state_d = S_MOVING;
          dir_d   = DIR_UP;
          tc_d    = '0;
        end else if (below) begin
          state_d = S_MOVING;
          dir_d   = DIR_DN;
          tc_d    = '0;
        end else begin
          dir_d = DIR_IDLE;
        end
      end
      S_MOVING: begin
        if (tc_q == TC_LAST) begin
          tc_d    = '0;
          floor_d = (dir_q == DIR_UP) ? floor_q + FLOOR_BITS'(1) : floor_q - FLOOR_BITS'(1);
          // Arrival decision looks at the floor just reached, never reversing here.
          if (|(pending_q & onehot(floor_d))) begin
            state_d = S_DOORS;
            dc_d    = '0;
          end else if ((dir_q == DIR_UP) ? above_of(pending_q, floor_d)
                                         : below_of(pending_q, floor_d)) begin
            state_d = S_MOVING;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          tc_d = tc_q + TC_W'(1);
        end
      end
      S_DOORS: begin
        if (restart) begin
          dc_d = '0;
        end else if (dc_q == DC_LAST) begin
          state_d = S_IDLE;
          dc_d    = '0;
        end else begin
          dc_d = dc_q + DC_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Any cycle that ends in DOORS_OPEN keeps the served floor's bit clear.
  always_comb begin
    clr_v     = (state_d == S_DOORS) ? onehot(floor_d) : '0;
    pending_d = (pending_q | set_v) & ~clr_v;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      dir_q     <= DIR_IDLE;
      floor_q   <= '0;
      pending_q <= '0;
      tc_q      <= '0;
      dc_q      <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      floor_q   <= floor_d;
      pending_q <= pending_d;
      tc_q      <= tc_d;
      dc_q      <= dc_d;
      ready_q   <= 1'b1;
    end
  end

  assign assign_ready  = ready_q;
  assign current_floor = floor_q;
  assign direction     = dir_q;
  assign pending       = pending_q;
  assign door_open     = (state_q == S_DOORS);
  assign motor_up      = (state_q == S_MOVING) && (dir_q == DIR_UP);
  assign motor_down    = (state_q == S_MOVING) && (dir_q == DIR_DN);

endmodule

// File: tb/tb_elevator_car_controller.sv
// Directed bench for elevator_car_controller: travel timing, SCAN ordering,
// door dwell/obstruction, assignment handling and mid-travel reset.
module tb_elevator_car_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       assign_valid = 1'b0;
  logic [2:0] assign_floor = 3'd0;
  logic       assign_ready;
  logic [6:0] car_button = 7'd0;
  logic       door_obstruct = 1'b0;
  logic [2:0] current_floor;
  logic [1:0] direction;
  logic       motor_up, motor_down, door_open;
  logic [6:0] pending;

  int   n_tests = 0;
  int   n_fail = 0;
  logic both_seen = 1'b0;
  int   n;

  always #5 clk = ~clk;

  elevator_car_controller #(
    .FLOOR_COUNT(7), .FLOOR_BITS(3), .TRAVEL_CYCLES(8), .DOOR_CYCLES(12)
  ) dut (
    .clk(clk), .reset(reset),
    .assign_valid(assign_valid), .assign_floor(assign_floor), .assign_ready(assign_ready),
    .car_button(car_button), .door_obstruct(door_obstruct),
    .current_floor(current_floor), .direction(direction),
    .motor_up(motor_up), .motor_down(motor_down), .door_open(door_open),
    .pending(pending)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    if (motor_up && motor_down) both_seen = 1'b1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    assign_valid = 1'b0;
    assign_floor = 3'd0;
    car_button = 7'd0;
    door_obstruct = 1'b0;
    tick;
    tick;
    reset = 1'b0;
  endtask

  // Waits for doors to close (if open) and then reopen; returns ticks used.
  task automatic wait_door_edge(input int budget, output int cnt);
    cnt = 0;
    while (door_open && cnt < budget) begin
      tick;
      cnt++;
    end
    while (!door_open && cnt < budget) begin
      tick;
      cnt++;
    end
  endtask

  initial begin
    // Reset values and a single cabin call to floor 3
    do_reset;
    chk("rst_floor", 32'(current_floor), 0);
    chk("rst_dir", 32'(direction), 0);
    chk("rst_door", 32'(door_open), 0);
    chk("rst_motors", 32'({motor_up, motor_down}), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_ready", 32'(assign_ready), 0);
    car_button = 7'b0001000;
    tick;
    car_button = 7'd0;
    chk("t1_pending_set", 32'(pending), 32'h08);
    chk("t1_ready", 32'(assign_ready), 1);
    tick;
    chk("t1_start_up", 32'({motor_up, motor_down, direction}), 32'b10_01);
    repeat (23) tick;
    chk("t1_floor2_moving", 32'({current_floor, motor_up}), 32'b010_1);
    tick;
    chk("t1_arrive3", 32'(current_floor), 3);
    chk("t1_door_open", 32'(door_open), 1);
    chk("t1_pending_clr", 32'(pending), 0);
    chk("t1_motor_off", 32'({motor_up, motor_down}), 0);
    n = 0;
    while (door_open && n < 100) begin
      n++;
      tick;
    end
    chk("t1_dwell", 32'(n), 12);
    tick;
    chk("t1_idle_dir", 32'(direction), 0);

    // SCAN: at floor 3 going up, serve 5 before 1
    do_reset;
    both_seen = 1'b0;
    car_button = 7'b0001000;
    tick;
    car_button = 7'd0;
    wait_door_edge(200, n);
    chk("t2_reach3_cycles", 32'(n), 25);
    assign_valid = 1'b1;
    assign_floor = 3'd5;
    tick;
    assign_floor = 3'd1;
    tick;
    assign_valid = 1'b0;
    chk("t2_pending", 32'(pending), 32'h22);
    wait_door_edge(200, n);
    chk("t2_to5_cycles", 32'(n), 27);
    chk("t2_floor5", 32'(current_floor), 5);
    wait_door_edge(200, n);
    chk("t2_to1_cycles", 32'(n), 45);
    chk("t2_floor1", 32'(current_floor), 1);
    chk("t2_dir_down", 32'(direction), 32'b10);
    chk("t2_pending_empty", 32'(pending), 0);

    // Door obstruction at floor 2
    car_button = 7'b0000100;
    tick;
    car_button = 7'd0;
    wait_door_edge(200, n);
    chk("t3_to2_cycles", 32'(n), 20);
    chk("t3_floor2", 32'(current_floor), 2);
    n = 0;
    while (door_open && n < 200) begin
      n++;
      if (n == 1) door_obstruct = 1'b1;
      if (n == 21) door_obstruct = 1'b0;
      tick;
    end
    door_obstruct = 1'b0;
    chk("t3_obstruct_dwell", 32'(n), 32);
    chk("t3_idle_motors", 32'({motor_up, motor_down}), 0);
    chk("motor_excl_a", 32'(both_seen), 0);

    // Assignment handling at floor 0
    do_reset;
    assign_valid = 1'b1;
    assign_floor = 3'd4;
    tick;
    chk("t4_not_ready_drop", 32'(pending), 0);
    assign_floor = 3'd0;
    tick;
    assign_valid = 1'b0;
    chk("t4_pending0", 32'(pending), 32'h01);
    tick;
    chk("t4_door_open", 32'(door_open), 1);
    chk("t4_no_motor", 32'({motor_up, motor_down, current_floor}), 0);
    chk("t4_pending_clr", 32'(pending), 0);
    assign_valid = 1'b1;
    assign_floor = 3'd7;
    tick;
    chk("t4_out_of_range", 32'(pending), 0);
    assign_floor = 3'd0;
    tick;
    assign_valid = 1'b0;
    chk("t4_same_floor_clear", 32'(pending), 0);
    n = 0;
    while (door_open && n < 100) begin
      n++;
      tick;
    end
    chk("t4_dwell_restart", 32'(n), 12);

    // Cabin call behind the car while travelling up
    do_reset;
    both_seen = 1'b0;
    car_button = 7'b0010000;
    tick;
    car_button = 7'd0;
    repeat (11) tick;
    chk("t5_between_1_2", 32'({current_floor, motor_up}), 32'b001_1);
    car_button = 7'b0000010;
    tick;
    car_button = 7'd0;
    wait_door_edge(200, n);
    chk("t5_to4_cycles", 32'(n), 21);
    chk("t5_floor4", 32'(current_floor), 4);
    chk("t5_pending1", 32'(pending), 32'h02);
    wait_door_edge(200, n);
    chk("t5_to1_cycles", 32'(n), 37);
    chk("t5_floor1", 32'(current_floor), 1);
    chk("motor_excl_b", 32'(both_seen), 0);

    // Reset mid-travel at floor 4
    car_button = 7'b1000000;
    tick;
    car_button = 7'd0;
    repeat (36) tick;
    chk("t6_floor4_moving", 32'({current_floor, motor_up}), 32'b100_1);
    repeat (3) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("t6_floor", 32'(current_floor), 0);
    chk("t6_pending", 32'(pending), 0);
    chk("t6_outputs", 32'({direction, motor_up, motor_down, door_open, assign_ready}), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
